awg_channel_sequencer: RTL and testbench

One playback channel of the dual-channel waveform generator: owns one external SRAM and one DAC. It accepts decoded per-channel commands from the SPI front end: SRAM write, set last index, set phase step, and run/stop. It arbitrates the single SRAM port between host writes and playback reads. In run mode it sequences a 32-bit phase accumulator through the table and strobes samples into the DAC. `top_system` instantiates two copies, one per channel.

---
 rtl/awg_channel_sequencer.sv | 173 +++++++++++++++++
 tb/tb_awg_channel_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/awg_channel_sequencer.sv
// One playback channel: arbitrates a single SRAM port between host writes and
// phase-accumulator playback into a DAC. AWG_WRITE_DURING_RUN_EN lets writes interleave with playback.
module awg_channel_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int PHASE_W = 32
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [15:0]       cmd_addr,
    input  logic [15:0]       cmd_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_wdata_oe,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_clock,
    output logic              running
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_W0   = 3'd1;
    localparam logic [2:0] S_W1   = 3'd2;
    localparam logic [2:0] S_W2   = 3'd3;
    localparam logic [2:0] S_P0   = 3'd4;
    localparam logic [2:0] S_P1   = 3'd5;
    localparam logic [2:0] S_P2   = 3'd6;
    localparam logic [2:0] S_P3   = 3'd7;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_LAST  = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_RUN   = 2'd3;

    localparam logic [PHASE_W-1:0] STEP_RST = PHASE_W'(1) << (PHASE_W - ADDR_W);

    logic [2:0]         state;
    logic [2:0]         state_next;
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] step;
    logic [ADDR_W-1:0]  last;
    logic [PHASE_W:0]   acc_sum;
    logic               acc_wrap;
    logic               cmd_accept;
    logic               do_write;
    logic               do_start;
    logic               do_stop;
    logic               enter_play;
    logic [ADDR_W-1:0]  play_index;

    // Writes are held off during playback unless interleaving is compiled in.
    always_comb begin
        cmd_ready = 1'b0;
        if (state == S_IDLE) begin
            cmd_ready = 1'b1;
        end else if (state == S_P3) begin
`ifdef AWG_WRITE_DURING_RUN_EN
            cmd_ready = 1'b1;
`else
            cmd_ready = (cmd_op != OP_WRITE);
`endif
        end
    end

    assign cmd_accept = cmd_valid && cmd_ready;

    assign acc_sum  = {1'b0, acc} + {1'b0, step};
    assign acc_wrap = acc_sum[PHASE_W] || (acc_sum[PHASE_W-1 -: ADDR_W] > last);

    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        do_start   = 1'b0;
        do_stop    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_accept && cmd_op == OP_WRITE) begin
                    do_write = 1'b1;
                end
                if (cmd_accept && cmd_op == OP_RUN && cmd_data[0]) begin
                    do_start = 1'b1;
                end
            end
            S_W0: state_next = S_W1;
            S_W1: state_next = S_W2;
            S_W2: state_next = running ? S_P0 : S_IDLE;
            S_P0: state_next = S_P1;
            S_P1: state_next = S_P2;
            S_P2: state_next = S_P3;
            S_P3: begin
                state_next = S_P0;
                if (cmd_accept && cmd_op == OP_WRITE) begin
                    do_write = 1'b1;
                end
                if (cmd_accept && cmd_op == OP_RUN && !cmd_data[0]) begin
                    do_stop = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (do_write) begin
            state_next = S_W0;
        end
        if (do_start) begin
            state_next = S_P0;
        end
        if (do_stop) begin
            state_next = S_IDLE;
        end
    end

    assign enter_play = (state_next == S_P0) && (state != S_P0);
    assign play_index = do_start ? '0 : acc[PHASE_W-1 -: ADDR_W];

    // Outputs are registered from the next state so each one is valid for the whole state.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state         <= S_IDLE;
            sram_we_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_wdata_oe <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            dac_data      <= '0;
            dac_clock     <= 1'b0;
            running       <= 1'b0;
            acc           <= '0;
            last          <= '1;
            step          <= STEP_RST;
        end else begin
            state         <= state_next;
            sram_we_n     <= (state_next != S_W1);
            sram_wdata_oe <= (state_next == S_W0) || (state_next == S_W1) || (state_next == S_W2);
            sram_oe_n     <= !((state_next == S_P0) || (state_next == S_P1) || (state_next == S_P2));
            dac_clock     <= (state_next == S_P3);

            if (do_write) begin
                sram_addr  <= ADDR_W'(cmd_addr);
                sram_wdata <= DATA_W'(cmd_data);
            end else if (enter_play) begin
                sram_addr <= play_index;
            end

            if (state == S_P1) begin
                dac_data <= sram_rdata;
            end

            if (do_start) begin
                acc     <= '0;
                running <= 1'b1;
            end else if (state == S_P0) begin
                acc <= acc_wrap ? '0 : acc_sum[PHASE_W-1:0];
            end

            if (do_stop) begin
                running <= 1'b0;
            end

            if (cmd_accept && cmd_op == OP_LAST) begin
                last <= ADDR_W'(cmd_data);
            end
            if (cmd_accept && cmd_op == OP_STEP) begin
                step <= PHASE_W'({cmd_addr, cmd_data});
            end
        end
    end

endmodule

// File: tb/tb_awg_channel_sequencer.sv
// Directed bench for awg_channel_sequencer with a behavioural asynchronous SRAM.
// Covers both builds of AWG_WRITE_DURING_RUN_EN.
module tb_awg_channel_sequencer;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_LAST  = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_RUN   = 2'd3;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_data;
    logic [15:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_wdata_oe;
    logic [15:0] sram_rdata;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic [15:0] dac_data;
    logic        dac_clock;
    logic        running;

    logic [15:0] sram_mem [0:65535];

    int tests = 0;
    int fails = 0;

    always #5 clk_sys = ~clk_sys;

    awg_channel_sequencer dut (
        .clk_sys       (clk_sys),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_wdata_oe (sram_wdata_oe),
        .sram_rdata    (sram_rdata),
        .sram_we_n     (sram_we_n),
        .sram_oe_n     (sram_oe_n),
        .dac_data      (dac_data),
        .dac_clock     (dac_clock),
        .running       (running)
    );

    always @(posedge clk_sys) begin
        if (!sram_we_n && sram_wdata_oe) begin
            sram_mem[sram_addr] <= sram_wdata;
        end
    end
    assign sram_rdata = sram_mem[sram_addr];

    typedef struct packed {
        logic we_n;
        logic wdata_oe;
        logic ready;
        logic chk_bus;
    } wr_vec_t;

    typedef struct packed {
        logic [31:0]         step;
        logic [15:0]         last;
        logic [0:8][15:0]    exp;
    } play_vec_t;

    wr_vec_t   wr_vecs [4];
    play_vec_t play_vecs [6];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Holds the command until a rising edge where it is accepted; returns 1 ns after that edge.
    task automatic apply_stimulus(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            #1;
            if (cmd_ready) begin
                @(posedge clk_sys);
                #1;
                ok = 1'b1;
            end else begin
                @(negedge clk_sys);
            end
        end
        cmd_valid = 1'b0;
        if (!ok) check_output("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rise(output logic [15:0] sample, output int cycles);
        logic prev;
        prev   = dac_clock;
        cycles = 0;
        sample = 16'hxxxx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            cycles++;
            if (dac_clock && !prev) begin
                sample = dac_data;
                return;
            end
            prev = dac_clock;
        end
        check_output("dac_clock_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_rise(input string tag, input logic [15:0] exp_s, input int exp_c);
        logic [15:0] s;
        int c;
        wait_rise(s, c);
        check_output({tag, " sample"}, 32'(s), 32'(exp_s));
        check_output({tag, " period"}, 32'(c), 32'(exp_c));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, " we_n"}, 32'(sram_we_n), 32'd1);
        check_output({tag, " oe_n"}, 32'(sram_oe_n), 32'd1);
        check_output({tag, " wdata_oe"}, 32'(sram_wdata_oe), 32'd0);
        check_output({tag, " addr"}, 32'(sram_addr), 32'd0);
        check_output({tag, " wdata"}, 32'(sram_wdata), 32'd0);
        check_output({tag, " dac_data"}, 32'(dac_data), 32'd0);
        check_output({tag, " dac_clock"}, 32'(dac_clock), 32'd0);
        check_output({tag, " running"}, 32'(running), 32'd0);
        check_output({tag, " ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        wr_vecs[0] = '{we_n: 1'b1, wdata_oe: 1'b1, ready: 1'b0, chk_bus: 1'b1};
        wr_vecs[1] = '{we_n: 1'b0, wdata_oe: 1'b1, ready: 1'b0, chk_bus: 1'b1};
        wr_vecs[2] = '{we_n: 1'b1, wdata_oe: 1'b1, ready: 1'b0, chk_bus: 1'b1};
        wr_vecs[3] = '{we_n: 1'b1, wdata_oe: 1'b0, ready: 1'b1, chk_bus: 1'b0};

        play_vecs[0] = '{step: 32'h0001_0000, last: 16'd3,
                         exp: {16'd10, 16'd20, 16'd30, 16'd40, 16'd10, 16'd20, 16'd30, 16'd40, 16'd10}};
        play_vecs[1] = '{step: 32'h0000_8000, last: 16'd3,
                         exp: {16'd10, 16'd10, 16'd20, 16'd20, 16'd30, 16'd30, 16'd40, 16'd40, 16'd10}};
        play_vecs[2] = '{step: 32'h0001_8000, last: 16'd3,
                         exp: {16'd10, 16'd20, 16'd40, 16'd10, 16'd20, 16'd40, 16'd10, 16'd20, 16'd40}};
        play_vecs[3] = '{step: 32'h0000_0000, last: 16'd3,
                         exp: {16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10}};
        play_vecs[4] = '{step: 32'h0001_0000, last: 16'd0,
                         exp: {16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10}};
        play_vecs[5] = '{step: 32'h8000_0000, last: 16'hFFFF,
                         exp: {16'd10, 16'd77, 16'd10, 16'd77, 16'd10, 16'd77, 16'd10, 16'd77, 16'd10}};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_WRITE;
        cmd_addr  = 16'h0;
        cmd_data  = 16'h0;
        repeat (3) @(negedge clk_sys);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk_sys);

        $display("[TB] idle write waveform");
        apply_stimulus(OP_WRITE, 16'h1234, 16'hABEF);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_sys);
            check_output($sformatf("write c%0d we_n", k + 1), 32'(sram_we_n), 32'(wr_vecs[k].we_n));
            check_output($sformatf("write c%0d wdata_oe", k + 1), 32'(sram_wdata_oe), 32'(wr_vecs[k].wdata_oe));
            check_output($sformatf("write c%0d ready", k + 1), 32'(cmd_ready), 32'(wr_vecs[k].ready));
            if (wr_vecs[k].chk_bus) begin
                check_output($sformatf("write c%0d addr", k + 1), 32'(sram_addr), 32'h1234);
                check_output($sformatf("write c%0d wdata", k + 1), 32'(sram_wdata), 32'hABEF);
            end
        end

        apply_stimulus(OP_WRITE, 16'd0, 16'd10);
        apply_stimulus(OP_WRITE, 16'd1, 16'd20);
        apply_stimulus(OP_WRITE, 16'd2, 16'd30);
        apply_stimulus(OP_WRITE, 16'd3, 16'd40);
        apply_stimulus(OP_WRITE, 16'h8000, 16'd77);

        $display("[TB] playback with reset step/last");
        apply_stimulus(OP_RUN, 16'd0, 16'd1);
        @(negedge clk_sys);
        check_output("p0 addr", 32'(sram_addr), 32'd0);
        check_output("p0 oe_n", 32'(sram_oe_n), 32'd0);
        check_output("p0 running", 32'(running), 32'd1);
        check_output("p0 dac_clock", 32'(dac_clock), 32'd0);
        @(negedge clk_sys);
        check_output("p1 oe_n", 32'(sram_oe_n), 32'd0);
        check_output("p1 ready", 32'(cmd_ready), 32'd0);
        @(negedge clk_sys);
        check_output("p2 dac_data early", 32'(dac_data), 32'd10);
        check_output("p2 dac_clock", 32'(dac_clock), 32'd0);
        @(negedge clk_sys);
        check_output("p3 dac_clock", 32'(dac_clock), 32'd1);
        check_output("p3 oe_n", 32'(sram_oe_n), 32'd1);
        expect_rise("default r2", 16'd20, 4);
        expect_rise("default r3", 16'd30, 4);
        expect_rise("default r4", 16'd40, 4);
        apply_stimulus(OP_RUN, 16'd0, 16'd0);
        check_output("default stop running", 32'(running), 32'd0);

        for (int v = 0; v < 6; v++) begin
            $display("[TB] playback vector %0d", v);
            apply_stimulus(OP_LAST, 16'd0, play_vecs[v].last);
            apply_stimulus(OP_STEP, play_vecs[v].step[31:16], play_vecs[v].step[15:0]);
            apply_stimulus(OP_RUN, 16'd0, 16'd1);
            for (int k = 0; k < 9; k++) begin
                expect_rise($sformatf("vec%0d r%0d", v, k), play_vecs[v].exp[k], 4);
            end
            apply_stimulus(OP_RUN, 16'd0, 16'd0);
            check_output($sformatf("vec%0d stop running", v), 32'(running), 32'd0);
            check_output($sformatf("vec%0d stop hold", v), 32'(dac_data), 32'(play_vecs[v].exp[8]));
            repeat (6) @(negedge clk_sys);
            check_output($sformatf("vec%0d idle hold", v), 32'(dac_data), 32'(play_vecs[v].exp[8]));
            check_output($sformatf("vec%0d idle dac_clock", v), 32'(dac_clock), 32'd0);
        end

        $display("[TB] write while running");
        apply_stimulus(OP_LAST, 16'd0, 16'd3);
        apply_stimulus(OP_STEP, 16'h0001, 16'h0000);
        apply_stimulus(OP_RUN, 16'd0, 16'd1);
        expect_rise("ilv r0", 16'd10, 4);
`ifdef AWG_WRITE_DURING_RUN_EN
        apply_stimulus(OP_WRITE, 16'd2, 16'd99);
        begin
            logic [15:0] s;
            int c;
            wait_rise(s, c);
            check_output("ilv r1 sample", 32'(s), 32'd20);
            check_output("ilv r1 period", 32'(c), 32'd7);
        end
        expect_rise("ilv r2", 16'd99, 4);
        expect_rise("ilv r3", 16'd40, 4);
        expect_rise("ilv r4", 16'd10, 4);
        expect_rise("ilv r5", 16'd20, 4);
        expect_rise("ilv r6", 16'd99, 4);
        apply_stimulus(OP_RUN, 16'd0, 16'd0);
`else
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_addr  = 16'd2;
        cmd_data  = 16'd99;
        for (int k = 0; k < 9; k++) begin
            #1;
            check_output($sformatf("held write ready c%0d", k), 32'(cmd_ready), 32'd0);
            if (k < 8) @(negedge clk_sys);
        end
        cmd_valid = 1'b0;
        apply_stimulus(OP_RUN, 16'd0, 16'd0);
        check_output("held stop running", 32'(running), 32'd0);
        apply_stimulus(OP_WRITE, 16'd2, 16'd99);
        repeat (4) @(negedge clk_sys);
        apply_stimulus(OP_RUN, 16'd0, 16'd1);
        expect_rise("held r0", 16'd10, 4);
        expect_rise("held r1", 16'd20, 4);
        expect_rise("held r2", 16'd99, 4);
        expect_rise("held r3", 16'd40, 4);
        apply_stimulus(OP_RUN, 16'd0, 16'd0);
`endif
        check_output("ilv stop running", 32'(running), 32'd0);

        $display("[TB] reset during write");
        apply_stimulus(OP_WRITE, 16'd5, 16'h5555);
        @(negedge clk_sys);
        @(negedge clk_sys);
        check_output("rst-w1 we_n before", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        @(posedge clk_sys);
        #1;
        check_reset_outputs("rst-w1");
        @(negedge clk_sys);
        rst = 1'b0;

        $display("[TB] reset during playback");
        apply_stimulus(OP_LAST, 16'd0, 16'd3);
        apply_stimulus(OP_STEP, 16'h8000, 16'h0000);
        apply_stimulus(OP_RUN, 16'd0, 16'd1);
        expect_rise("rst-play r0", 16'd10, 4);
        @(negedge clk_sys);
        rst = 1'b1;
        @(posedge clk_sys);
        #1;
        check_reset_outputs("rst-play");
        @(negedge clk_sys);
        rst = 1'b0;

        apply_stimulus(OP_RUN, 16'd0, 16'd1);
        expect_rise("post-rst r0", 16'd10, 4);
        expect_rise("post-rst r1", 16'd20, 4);
        expect_rise("post-rst r2", 16'd99, 4);
        apply_stimulus(OP_RUN, 16'd0, 16'd0);
        check_output("post-rst stop running", 32'(running), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
